ps2_key_event: RTL and testbench
================================

// Module: ps2_key_event
// PURPOSE
//  Sits downstream of the PS/2 keyboard controller and consumes its byte FIFO via the ready/nextdata_n pop handshake.
//  Assembles make/break/extended scan-code sequences into key events.
//  Tracks the currently held key and counts distinct presses, ignoring typematic repeats.
//  Feeds the board-level display/LED logic with the held code, its ASCII value, the press count and per-event pulses.
// PARAMETERS
//  CNT_W         8   width of press_cnt; counter wraps modulo 2**CNT_W
//  IGNORE_REPEAT 1   1: a repeat make of the held key does not increment press_cnt
// PORTS
//  clk            in   1      clock
//  rst            in   1      reset, synchronous, active-high
//  kb_data        in   8      head byte of controller FIFO
//  kb_ready       in   1      FIFO non-empty
//  kb_overflow    in   1      controller FIFO overflow flag
//  kb_nextdata_n  out  1      active-low pop; low for exactly one cycle per accepted byte
//  key_down       out  1      a key is currently held
//  key_code       out  8      last make code; retained after release
//  key_ext        out  1      key_code came from an E0-prefixed sequence
//  key_ascii      out  8      lower-case ASCII of key_code; 8'h00 if unmapped or key_ext=1
//  press_cnt      out  CNT_W  number of distinct presses
//  evt_valid      out  1      one-cycle pulse per completed make or break sequence
//  evt_make       out  1      1=make, 0=break; valid while evt_valid=1
//  evt_repeat     out  1      make of the already-held key (typematic repeat)
//  evt_code       out  8      code of the event (prefix bytes stripped)
//  ovf_sticky     out  1      set when kb_overflow is seen high; cleared only by rst
// BEHAVIOUR
//  Reset: kb_nextdata_n=1; FSM=IDLE; every other output=0. Reset mid-sequence discards any pending prefix.
//  Accept: a byte is accepted at an edge where kb_ready=1 and kb_nextdata_n=1.
//   At that edge kb_nextdata_n goes 0 for one cycle, then returns to 1.
//   Maximum rate: one byte per 2 cycles; a back-to-back pop is never issued.
//  Latency: FSM state, key_* outputs and evt_* outputs update at the accepting edge.
//   evt_valid is high in the same cycle that kb_nextdata_n is low.
//  evt_valid is 0 in every cycle with no completed sequence; evt_make/evt_repeat/evt_code hold their last values.
//  FSM states: IDLE, BRK (after F0), EXT (after E0), EXT_BRK (after E0 F0).
//   IDLE:    F0->BRK; E0->EXT; other->make(code, ext=0), stay IDLE
//   EXT:     F0->EXT_BRK; E0->stay EXT; other->make(code, ext=1), ->IDLE
//   BRK:     any byte->break(code, ext=0), ->IDLE
//   EXT_BRK: any byte->break(code, ext=1), ->IDLE
//   Bytes 8'h00 and 8'hFF (controller error codes) in any state: popped, no event, FSM->IDLE.
//  Make event:
//   If key_down=1 and {code,ext}=={key_code,key_ext}: evt_repeat=1; press_cnt unchanged when IGNORE_REPEAT=1.
//   Otherwise: key_code/key_ext/key_ascii load; key_down=1; press_cnt+1 (wraps at all-ones->0); evt_repeat=0.
//   A make of a new key while another is held replaces it (the last key pressed wins).
//  Break event: if it matches {key_code,key_ext}, key_down=0; otherwise held state is unchanged.
//   The event is reported in either case.
//  key_ascii is looked up from the incoming byte and registered with key_code.
//   It covers letters, digits and space; all other codes give 8'h00.
//  ovf_sticky: set at any edge where kb_overflow=1, independent of the FSM.
// STRUCTURE
//  ps2_pkg: FSM state encoding; constants SC_BREAK=8'hF0, SC_EXT=8'hE0, SC_ERR0=8'h00, SC_ERR1=8'hFF.
//  Sub-module ps2_scan2ascii: combinational set-2 scan code to ASCII ROM (8-bit in, 8-bit out).
//  Top level: handshake/pop logic, FSM, held-key registers and press counter.
// TESTING
//  1. Reset, then FIFO 15 -> one pop; key_code=15, key_ascii=71, key_down=1, press_cnt=1, evt_make=1.
//  2. FIFO 15,15,15 after 1 -> 2 evt_valid pulses with evt_repeat=1; press_cnt stays 1.
//     Then F0,15 -> break event; key_down=0; key_code stays 15.
//  3. FIFO E0,75 -> key_ext=1, key_ascii=00, press_cnt+1.
//     Then E0,F0,75 -> key_down=0; E0 and F0 produce no evt_valid.
//  4. kb_ready held 1 for 10 cycles -> kb_nextdata_n toggles 1,0,1,0,...; never 0 on two consecutive cycles.
//  5. rst pulse right after F0 is accepted, then FIFO 1C -> make 1C (ascii 61), not a break; press_cnt=1.
//  6. CNT_W=2, 5 distinct keys -> press_cnt 1,2,3,0,1.
//     kb_overflow pulsed for 1 cycle -> ovf_sticky stays 1 until rst.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 key-event definitions: FSM encoding and set-2 control byte values.
package ps2_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StBrk,
        StExt,
        StExtBrk
    } ps2_state_e;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_ERR0  = 8'h00;
    localparam logic [7:0] SC_ERR1  = 8'hFF;

    // Controller error/overrun codes carry no key information.
    function automatic logic is_err_code(input logic [7:0] code);
        return (code == SC_ERR0) || (code == SC_ERR1);
    endfunction

endpackage

// File: rtl/ps2_scan2ascii.sv
// Combinational set-2 scan code to lower-case ASCII lookup (letters, digits, space).
module ps2_scan2ascii (
    input  logic [7:0] scan_code,
    output logic [7:0] ascii
);

    // Unmapped codes return 8'h00.
    always_comb begin
        ascii = 8'h00;
        unique case (scan_code)
            8'h1C: ascii = 8'h61; // a
            8'h32: ascii = 8'h62; // b
            8'h21: ascii = 8'h63; // c
            8'h23: ascii = 8'h64; // d
            8'h24: ascii = 8'h65; // e
            8'h2B: ascii = 8'h66; // f
            8'h34: ascii = 8'h67; // g
            8'h33: ascii = 8'h68; // h
            8'h43: ascii = 8'h69; // i
            8'h3B: ascii = 8'h6A; // j
            8'h42: ascii = 8'h6B; // k
            8'h4B: ascii = 8'h6C; // l
            8'h3A: ascii = 8'h6D; // m
            8'h31: ascii = 8'h6E; // n
            8'h44: ascii = 8'h6F; // o
            8'h4D: ascii = 8'h70; // p
            8'h15: ascii = 8'h71; // q
            8'h2D: ascii = 8'h72; // r
            8'h1B: ascii = 8'h73; // s
            8'h2C: ascii = 8'h74; // t
            8'h3C: ascii = 8'h75; // u
            8'h2A: ascii = 8'h76; // v
            8'h1D: ascii = 8'h77; // w
            8'h22: ascii = 8'h78; // x
            8'h35: ascii = 8'h79; // y
            8'h1A: ascii = 8'h7A; // z
            8'h45: ascii = 8'h30; // 0
            8'h16: ascii = 8'h31; // 1
            8'h1E: ascii = 8'h32; // 2
            8'h26: ascii = 8'h33; // 3
            8'h25: ascii = 8'h34; // 4
            8'h2E: ascii = 8'h35; // 5
            8'h36: ascii = 8'h36; // 6
            8'h3D: ascii = 8'h37; // 7
            8'h3E: ascii = 8'h38; // 8
            8'h46: ascii = 8'h39; // 9
            8'h29: ascii = 8'h20; // space
            default: ascii = 8'h00;
        endcase
    end

endmodule

// File: rtl/ps2_key_event.sv
// PS/2 key-event assembler: pops the controller byte FIFO, decodes make/break/E0
// sequences, tracks the held key and counts distinct presses.
module ps2_key_event
    import ps2_pkg::*;
#(
    parameter int unsigned CNT_W         = 8,
    parameter bit          IGNORE_REPEAT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       kb_data,
    input  logic             kb_ready,
    input  logic             kb_overflow,
    output logic             kb_nextdata_n,
    output logic             key_down,
    output logic [7:0]       key_code,
    output logic             key_ext,
    output logic [7:0]       key_ascii,
    output logic [CNT_W-1:0] press_cnt,
    output logic             evt_valid,
    output logic             evt_make,
    output logic             evt_repeat,
    output logic [7:0]       evt_code,
    output logic             ovf_sticky
);

    ps2_state_e       state_q, state_d;
    logic             nextdata_n_q, nextdata_n_d;
    logic             key_down_q, key_down_d;
    logic [7:0]       key_code_q, key_code_d;
    logic             key_ext_q, key_ext_d;
    logic [7:0]       key_ascii_q, key_ascii_d;
    logic [CNT_W-1:0] press_cnt_q, press_cnt_d;
    logic             evt_valid_q, evt_valid_d;
    logic             evt_make_q, evt_make_d;
    logic             evt_repeat_q, evt_repeat_d;
    logic [7:0]       evt_code_q, evt_code_d;
    logic             ovf_q, ovf_d;

    logic       accept;
    logic       make_ev;
    logic       break_ev;
    logic       ev_ext;
    logic       held_match;
    logic [7:0] lut_ascii;

    ps2_scan2ascii u_scan2ascii (
        .scan_code (kb_data),
        .ascii     (lut_ascii)
    );

    // The pop pulse itself blocks the next accept, so pops are never back-to-back.
    assign accept     = kb_ready && nextdata_n_q;
    assign held_match = key_down_q && (kb_data == key_code_q) && (ev_ext == key_ext_q);

    // Sequence decode: next FSM state and which event (if any) this byte completes.
    always_comb begin
        state_d  = state_q;
        make_ev  = 1'b0;
        break_ev = 1'b0;
        ev_ext   = 1'b0;
        if (accept) begin
            if (is_err_code(kb_data)) begin
                state_d = StIdle;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (kb_data == SC_BREAK)    state_d = StBrk;
                        else if (kb_data == SC_EXT) state_d = StExt;
                        else                        make_ev = 1'b1;
                    end
                    StExt: begin
                        ev_ext = 1'b1;
                        if (kb_data == SC_BREAK) begin
                            state_d = StExtBrk;
                        end else if (kb_data != SC_EXT) begin
                            make_ev = 1'b1;
                            state_d = StIdle;
                        end
                    end
                    StBrk: begin
                        break_ev = 1'b1;
                        state_d  = StIdle;
                    end
                    StExtBrk: begin
                        ev_ext   = 1'b1;
                        break_ev = 1'b1;
                        state_d  = StIdle;
                    end
                    default: state_d = StIdle;
                endcase
            end
        end
    end

    // Held-key, counter, event and handshake next-state.
    always_comb begin
        nextdata_n_d = ~accept;
        key_down_d   = key_down_q;
        key_code_d   = key_code_q;
        key_ext_d    = key_ext_q;
        key_ascii_d  = key_ascii_q;
        press_cnt_d  = press_cnt_q;
        evt_valid_d  = 1'b0;
        evt_make_d   = evt_make_q;
        evt_repeat_d = evt_repeat_q;
        evt_code_d   = evt_code_q;
        ovf_d        = ovf_q | kb_overflow;

        if (make_ev) begin
            evt_valid_d  = 1'b1;
            evt_make_d   = 1'b1;
            evt_code_d   = kb_data;
            evt_repeat_d = held_match;
            if (held_match) begin
                if (!IGNORE_REPEAT) press_cnt_d = press_cnt_q + CNT_W'(1);
            end else begin
                // Last key pressed wins, even if another is still held.
                key_down_d  = 1'b1;
                key_code_d  = kb_data;
                key_ext_d   = ev_ext;
                key_ascii_d = ev_ext ? 8'h00 : lut_ascii;
                press_cnt_d = press_cnt_q + CNT_W'(1);
            end
        end else if (break_ev) begin
            evt_valid_d  = 1'b1;
            evt_make_d   = 1'b0;
            evt_code_d   = kb_data;
            evt_repeat_d = 1'b0;
            if (held_match) key_down_d = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            nextdata_n_q <= 1'b1;
            key_down_q   <= 1'b0;
            key_code_q   <= 8'h00;
            key_ext_q    <= 1'b0;
            key_ascii_q  <= 8'h00;
            press_cnt_q  <= '0;
            evt_valid_q  <= 1'b0;
            evt_make_q   <= 1'b0;
            evt_repeat_q <= 1'b0;
            evt_code_q   <= 8'h00;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            nextdata_n_q <= nextdata_n_d;
            key_down_q   <= key_down_d;
            key_code_q   <= key_code_d;
            key_ext_q    <= key_ext_d;
            key_ascii_q  <= key_ascii_d;
            press_cnt_q  <= press_cnt_d;
            evt_valid_q  <= evt_valid_d;
            evt_make_q   <= evt_make_d;
            evt_repeat_q <= evt_repeat_d;
            evt_code_q   <= evt_code_d;
            ovf_q        <= ovf_d;
        end
    end

    assign kb_nextdata_n = nextdata_n_q;
    assign key_down      = key_down_q;
    assign key_code      = key_code_q;
    assign key_ext       = key_ext_q;
    assign key_ascii     = key_ascii_q;
    assign press_cnt     = press_cnt_q;
    assign evt_valid     = evt_valid_q;
    assign evt_make      = evt_make_q;
    assign evt_repeat    = evt_repeat_q;
    assign evt_code      = evt_code_q;
    assign ovf_sticky    = ovf_q;

endmodule

// File: tb/tb_ps2_key_event.sv
// Directed bench for ps2_key_event: byte-sequence table plus handshake, reset and
// overflow sequences. A second instance with a 2-bit counter checks wrap-around.
module tb_ps2_key_event;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] kb_data = 8'h00;
    logic       kb_ready = 1'b0;
    logic       kb_overflow = 1'b0;

    logic       nd, key_down, key_ext, evt_valid, evt_make, evt_repeat, ovf_sticky;
    logic [7:0] key_code, key_ascii, evt_code, press_cnt;

    logic       nd2, key_down2, key_ext2, evt_valid2, evt_make2, evt_repeat2, ovf_sticky2;
    logic [7:0] key_code2, key_ascii2, evt_code2;
    logic [1:0] press_cnt2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ps2_key_event #(.CNT_W(8), .IGNORE_REPEAT(1'b1)) dut (
        .clk           (clk),
        .rst           (rst),
        .kb_data       (kb_data),
        .kb_ready      (kb_ready),
        .kb_overflow   (kb_overflow),
        .kb_nextdata_n (nd),
        .key_down      (key_down),
        .key_code      (key_code),
        .key_ext       (key_ext),
        .key_ascii     (key_ascii),
        .press_cnt     (press_cnt),
        .evt_valid     (evt_valid),
        .evt_make      (evt_make),
        .evt_repeat    (evt_repeat),
        .evt_code      (evt_code),
        .ovf_sticky    (ovf_sticky)
    );

    ps2_key_event #(.CNT_W(2), .IGNORE_REPEAT(1'b1)) dut2 (
        .clk           (clk),
        .rst           (rst),
        .kb_data       (kb_data),
        .kb_ready      (kb_ready),
        .kb_overflow   (kb_overflow),
        .kb_nextdata_n (nd2),
        .key_down      (key_down2),
        .key_code      (key_code2),
        .key_ext       (key_ext2),
        .key_ascii     (key_ascii2),
        .press_cnt     (press_cnt2),
        .evt_valid     (evt_valid2),
        .evt_make      (evt_make2),
        .evt_repeat    (evt_repeat2),
        .evt_code      (evt_code2),
        .ovf_sticky    (ovf_sticky2)
    );

    typedef struct {
        logic [7:0] data;
        logic       k_down;
        logic [7:0] k_code;
        logic       k_ext;
        logic [7:0] k_ascii;
        logic [7:0] cnt;
        logic       e_valid;
        logic       e_make;
        logic       e_rep;
        logic [7:0] e_code;
    } vec_t;

    vec_t vecs[19];

    function automatic vec_t mk(input int d, input int kd, input int kc, input int ke,
                                input int ka, input int cnt, input int ev, input int em,
                                input int er, input int ec);
        vec_t v;
        v.data    = 8'(d);
        v.k_down  = kd[0];
        v.k_code  = 8'(kc);
        v.k_ext   = ke[0];
        v.k_ascii = 8'(ka);
        v.cnt     = 8'(cnt);
        v.e_valid = ev[0];
        v.e_make  = em[0];
        v.e_rep   = er[0];
        v.e_code  = 8'(ec);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Present one byte at a negedge once the pop pulse has cleared; it is accepted at the
    // following posedge. Outputs are left for sampling 1 time unit after that edge.
    task automatic send_byte(input logic [7:0] b);
        int guard = 0;
        @(negedge clk);
        while (nd !== 1'b1 && guard < 8) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 8) chk("pop_idle_timeout", 32'(nd), 32'd1);
        kb_data  = b;
        kb_ready = 1'b1;
        @(posedge clk);
        #1;
        kb_ready = 1'b0;
    endtask

    task automatic pulse_rst();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_nd"},        32'(nd), 32'd1);
        chk({tag, "_key_down"},  32'(key_down), 32'd0);
        chk({tag, "_key_code"},  32'(key_code), 32'd0);
        chk({tag, "_key_ascii"}, 32'(key_ascii), 32'd0);
        chk({tag, "_press_cnt"}, 32'(press_cnt), 32'd0);
        chk({tag, "_evt_valid"}, 32'(evt_valid), 32'd0);
        chk({tag, "_evt_code"},  32'(evt_code), 32'd0);
        chk({tag, "_ovf"},       32'(ovf_sticky), 32'd0);
    endtask

    initial begin
        //           data  kd  code ext ascii cnt  ev em er code
        vecs[0]  = mk('h15, 1, 'h15, 0, 'h71, 1,   1, 1, 0, 'h15);
        vecs[1]  = mk('h15, 1, 'h15, 0, 'h71, 1,   1, 1, 1, 'h15);
        vecs[2]  = mk('h15, 1, 'h15, 0, 'h71, 1,   1, 1, 1, 'h15);
        vecs[3]  = mk('hF0, 1, 'h15, 0, 'h71, 1,   0, 1, 1, 'h15);
        vecs[4]  = mk('h15, 0, 'h15, 0, 'h71, 1,   1, 0, 0, 'h15);
        vecs[5]  = mk('hE0, 0, 'h15, 0, 'h71, 1,   0, 0, 0, 'h15);
        vecs[6]  = mk('h75, 1, 'h75, 1, 'h00, 2,   1, 1, 0, 'h75);
        vecs[7]  = mk('hE0, 1, 'h75, 1, 'h00, 2,   0, 1, 0, 'h75);
        vecs[8]  = mk('hF0, 1, 'h75, 1, 'h00, 2,   0, 1, 0, 'h75);
        vecs[9]  = mk('h75, 0, 'h75, 1, 'h00, 2,   1, 0, 0, 'h75);
        vecs[10] = mk('h1C, 1, 'h1C, 0, 'h61, 3,   1, 1, 0, 'h1C);
        vecs[11] = mk('h32, 1, 'h32, 0, 'h62, 4,   1, 1, 0, 'h32);
        vecs[12] = mk('hF0, 1, 'h32, 0, 'h62, 4,   0, 1, 0, 'h32);
        vecs[13] = mk('h1C, 1, 'h32, 0, 'h62, 4,   1, 0, 0, 'h1C);
        vecs[14] = mk('hE0, 1, 'h32, 0, 'h62, 4,   0, 0, 0, 'h1C);
        vecs[15] = mk('h00, 1, 'h32, 0, 'h62, 4,   0, 0, 0, 'h1C);
        vecs[16] = mk('h32, 1, 'h32, 0, 'h62, 4,   1, 1, 1, 'h32);
        vecs[17] = mk('hFF, 1, 'h32, 0, 'h62, 4,   0, 1, 1, 'h32);
        vecs[18] = mk('h45, 1, 'h45, 0, 'h30, 5,   1, 1, 0, 'h45);

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_reset_state("reset");

        // Table: each byte is one pop; state and event outputs checked right after.
        for (int i = 0; i < 19; i++) begin
            send_byte(vecs[i].data);
            chk($sformatf("v%0d_nd", i),        32'(nd), 32'd0);
            chk($sformatf("v%0d_key_down", i),  32'(key_down), 32'(vecs[i].k_down));
            chk($sformatf("v%0d_key_code", i),  32'(key_code), 32'(vecs[i].k_code));
            chk($sformatf("v%0d_key_ext", i),   32'(key_ext), 32'(vecs[i].k_ext));
            chk($sformatf("v%0d_key_ascii", i), 32'(key_ascii), 32'(vecs[i].k_ascii));
            chk($sformatf("v%0d_press_cnt", i), 32'(press_cnt), 32'(vecs[i].cnt));
            chk($sformatf("v%0d_cnt_w2", i),    32'(press_cnt2), 32'(vecs[i].cnt[1:0]));
            chk($sformatf("v%0d_evt_valid", i), 32'(evt_valid), 32'(vecs[i].e_valid));
            chk($sformatf("v%0d_evt_make", i),  32'(evt_make), 32'(vecs[i].e_make));
            chk($sformatf("v%0d_evt_rep", i),   32'(evt_repeat), 32'(vecs[i].e_rep));
            chk($sformatf("v%0d_evt_code", i),  32'(evt_code), 32'(vecs[i].e_code));
            // evt_valid is a single-cycle pulse and the pop returns high.
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_nd_release", i),  32'(nd), 32'd1);
            chk($sformatf("v%0d_evt_clear", i),   32'(evt_valid), 32'd0);
        end

        // kb_ready held high: pops alternate, never two low cycles in a row.
        @(negedge clk);
        kb_data  = 8'h45;
        kb_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("hold_nd_c%0d", i), 32'(nd), (i % 2 == 0) ? 32'd0 : 32'd1);
        end
        @(negedge clk);
        kb_ready = 1'b0;
        chk("hold_press_cnt", 32'(press_cnt), 32'd5);
        chk("hold_evt_rep",   32'(evt_repeat), 32'd1);

        // Reset right after F0 discards the pending break.
        send_byte(8'hF0);
        pulse_rst();
        chk_reset_state("midseq_rst");
        send_byte(8'h1C);
        chk("post_rst_evt_valid", 32'(evt_valid), 32'd1);
        chk("post_rst_evt_make",  32'(evt_make), 32'd1);
        chk("post_rst_key_down",  32'(key_down), 32'd1);
        chk("post_rst_key_ascii", 32'(key_ascii), 32'h61);
        chk("post_rst_press_cnt", 32'(press_cnt), 32'd1);
        chk("post_rst_cnt_w2",    32'(press_cnt2), 32'd1);

        // Overflow flag is sticky until reset.
        chk("ovf_before", 32'(ovf_sticky), 32'd0);
        @(negedge clk);
        kb_overflow = 1'b1;
        @(negedge clk);
        kb_overflow = 1'b0;
        chk("ovf_set", 32'(ovf_sticky), 32'd1);
        repeat (4) @(negedge clk);
        send_byte(8'h32);
        chk("ovf_hold", 32'(ovf_sticky), 32'd1);
        pulse_rst();
        chk("ovf_cleared", 32'(ovf_sticky), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
